// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the BCD scan display: digit geometry, 7-seg patterns, FSM encoding.
package bcd_scan_display_pkg;

  localparam int unsigned N_DIGITS = 5;
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_W    = N_DIGITS * DIGIT_W;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned IDX_W    = $clog2(N_DIGITS);

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_scan_display_if.sv
// Display bus: load/bcd/blank_lz toward the scanner, an/seg/frame_done back out.
//   master: drives load, bcd, blank_lz; observes an, seg, frame_done
//   slave : the scanner side
interface bcd_scan_display_if;
  import bcd_scan_display_pkg::*;

  logic             load;
  logic [BCD_W-1:0] bcd;
  logic             blank_lz;
  logic [N_DIGITS-1:0] an;
  logic [SEG_W-1:0] seg;
  logic             frame_done;

  modport master (output load, bcd, blank_lz, input an, seg, frame_done);
  modport slave  (input load, bcd, blank_lz, output an, seg, frame_done);
endinterface

// File: rtl/bcd_scan_display_seg7_dec.sv
// BCD nibble to active-high 7-segment pattern; A-F render as a dash.
//   nibble_i : 4-bit digit
//   seg_c_o  : combinational pattern {g,f,e,d,c,b,a}
module seg7_dec
  import bcd_scan_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble_i,
  output logic [SEG_W-1:0]   seg_c_o
);

  always_comb begin
    seg_c_o = SEG_DASH;
    case (nibble_i)
      4'd0: seg_c_o = SEG_0;
      4'd1: seg_c_o = SEG_1;
      4'd2: seg_c_o = SEG_2;
      4'd3: seg_c_o = SEG_3;
      4'd4: seg_c_o = SEG_4;
      4'd5: seg_c_o = SEG_5;
      4'd6: seg_c_o = SEG_6;
      4'd7: seg_c_o = SEG_7;
      4'd8: seg_c_o = SEG_8;
      4'd9: seg_c_o = SEG_9;
      default: seg_c_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 5-digit common-anode 7-seg driver with frame-synchronous
// data swap and optional leading-zero blanking.
//   clk, rst : clock, async active-high reset
//   disp     : slave side of the display bus (load/bcd/blank_lz in,
//              an/seg/frame_done out, all outputs registered)
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_scan_display_if.slave  disp
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [N_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW  ? '1 : '0;
  localparam logic [SEG_W-1:0]    SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  state_e              state_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BCD_W-1:0]    shadow_q, shadow_d;
  logic [BCD_W-1:0]    frame_q, frame_d;
  logic [N_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]    seg_q;
  logic                frame_done_q;

  logic                tick_c, wrap_c;
  logic [DIGIT_W-1:0]  nibble_c;
  logic [SEG_W-1:0]    pat_c;
  logic [N_DIGITS-1:0] zero_above_c;   // digit i and everything above it are zero
  logic                blank_c;
  logic [N_DIGITS-1:0] an_hi_c;

  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign wrap_c = tick_c && (idx_q == IDX_W'(N_DIGITS - 1));

  // Divider, index, shadow and frame next-state
  always_comb begin
    div_d    = tick_c ? '0 : div_q + DIV_W'(1);
    idx_d    = idx_q;
    if (tick_c) idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
    shadow_d = disp.load ? disp.bcd : shadow_q;
    frame_d  = frame_q;
    // A load on the wrap bypasses the shadow so it lands in the starting frame
    if (wrap_c)                          frame_d = disp.load ? disp.bcd : shadow_q;
    else if (state_q == IDLE && disp.load) frame_d = disp.bcd;
  end

  // Select the digit about to be shown; frame_d so the wrap slot sees the new frame
  always_comb begin
    nibble_c = '0;
    zero_above_c = '0;
    blank_c = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above_c[i] = (frame_d[DIGIT_W*i +: DIGIT_W] == '0) &&
                        ((i == N_DIGITS - 1) ? 1'b1 : zero_above_c[(i == N_DIGITS - 1) ? i : i + 1]);
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble_c = frame_d[DIGIT_W*i +: DIGIT_W];
        blank_c  = (i != 0) && disp.blank_lz && zero_above_c[i];
      end
    end
    an_hi_c = blank_c ? '0 : (N_DIGITS'(1) << idx_d);
  end

  seg7_dec u_dec (
    .nibble_i (nibble_c),
    .seg_c_o  (pat_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      frame_q      <= '0;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      frame_done_q <= (state_q == SCAN) && wrap_c;
      case (state_q)
        IDLE: if (disp.load) state_q <= SCAN;
        SCAN: begin
          if (tick_c) begin
            an_q  <= AN_ACTIVE_LOW  ? ~an_hi_c : an_hi_c;
            seg_q <= SEG_ACTIVE_LOW ? ~(blank_c ? SEG_OFF : pat_c)
                                    :  (blank_c ? SEG_OFF : pat_c);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp.an         = an_q;
  assign disp.seg        = seg_q;
  assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with CLK_DIV=4 and active-low outputs.
module tb_bcd_scan_display;

  localparam int unsigned CLK_DIV = 4;
  localparam logic [24:0] AN_STD = {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  bcd_scan_display_if dif ();

  bcd_scan_display #(
    .CLK_DIV        (CLK_DIV),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (dif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [19:0] w);
    dif.bcd  = w;
    dif.load = 1'b1;
    step();
    dif.load = 1'b0;
  endtask

  // Wait (bounded) until the sample right after a wrap tick
  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (dif.frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!seen) $display("FAIL %s: frame_done not seen within 60 cycles", name);
    else passed++;
  endtask

  // Check one full frame from its first cycle; optional load at sample load_at
  task automatic check_frame(input string name, input logic [24:0] an_v,
                             input logic [34:0] seg_v, input int load_at,
                             input logic [19:0] new_bcd);
    for (int k = 0; k < 20; k++) begin
      logic [4:0] ea;
      logic [6:0] es;
      logic       ef;
      ea = an_v[5*(k/4) +: 5];
      es = seg_v[7*(k/4) +: 7];
      ef = (k == 0);
      checks++;
      if (dif.an !== ea) $display("FAIL %s an k=%0d: got %h want %h", name, k, dif.an, ea);
      else passed++;
      checks++;
      if (dif.seg !== es) $display("FAIL %s seg k=%0d: got %h want %h", name, k, dif.seg, es);
      else passed++;
      checks++;
      if (dif.frame_done !== ef) $display("FAIL %s frame_done k=%0d: got %b want %b", name, k, dif.frame_done, ef);
      else passed++;
      if (k == load_at) begin
        dif.bcd  = new_bcd;
        dif.load = 1'b1;
      end
      step();
      dif.load = 1'b0;
    end
  endtask

  task automatic check_blank(input string name, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      checks++;
      if (dif.an !== 5'h1F || dif.seg !== 7'h7F || dif.frame_done !== 1'b0)
        $display("FAIL %s k=%0d: got an=%h seg=%h fd=%b want an=1f seg=7f fd=0",
                 name, k, dif.an, dif.seg, dif.frame_done);
      else passed++;
      step();
    end
  endtask

  task automatic test_reset();
    dif.load = 1'b0; dif.bcd = '0; dif.blank_lz = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_blank("reset_idle", 40);
  endtask

  task automatic test_scan();
    dif.blank_lz = 1'b0;
    load_word(20'h12345);
    wait_frame("scan_wait");
    check_frame("scan_f1", AN_STD, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, -1, '0);
    wait_frame("scan_wait2");
    check_frame("scan_f2", AN_STD, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, -1, '0);
  endtask

  task automatic test_blank_lz();
    dif.blank_lz = 1'b1;
    load_word(20'h00042);
    wait_frame("lz42_wait");
    check_frame("lz42", {5'h1F, 5'h1F, 5'h1F, 5'h1D, 5'h1E},
                {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, -1, '0);
    load_word(20'h00000);
    wait_frame("lz0_wait");
    check_frame("lz0", {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1E},
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, -1, '0);
  endtask

  task automatic test_back_to_back();
    dif.blank_lz = 1'b0;
    load_word(20'h12345);
    wait_frame("mid_wait");
    // Load 99999 at the start of digit 2's slot: current frame must stay 12345
    check_frame("mid_old", AN_STD, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 8, 20'h99999);
    wait_frame("mid_wait2");
    // Load 13579 on the wrap tick itself: the very next frame must show it
    check_frame("mid_new", AN_STD, {5{7'h10}}, 19, 20'h13579);
    wait_frame("wrap_wait");
    check_frame("wrap_bypass", AN_STD, {7'h79, 7'h30, 7'h12, 7'h78, 7'h10}, -1, '0);
  endtask

  task automatic test_dash_and_async_reset();
    load_word(20'h1234A);
    wait_frame("dash_wait");
    check_frame("dash", AN_STD, {7'h79, 7'h24, 7'h30, 7'h19, 7'h3F}, -1, '0);
    step(); step();
    rst = 1'b1;
    #1;
    checks++;
    if (dif.an !== 5'h1F || dif.seg !== 7'h7F || dif.frame_done !== 1'b0)
      $display("FAIL async_rst: got an=%h seg=%h fd=%b want an=1f seg=7f fd=0",
               dif.an, dif.seg, dif.frame_done);
    else passed++;
    #2;
    rst = 1'b0;
    step();
    check_blank("post_rst_idle", 30);
    load_word(20'h12345);
    wait_frame("restart_wait");
    check_frame("restart", AN_STD, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, -1, '0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_lz();
    test_back_to_back();
    test_dash_and_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Consumes the 20-bit packed BCD word produced by the binary-to-BCD converter. Digit 4 is the most significant and digit 0 is the units.
- Drives a 5-digit, time-multiplexed, common-anode 7-segment display.
- Holds a shadow copy of the last loaded word and scans one digit per refresh tick.
- Swaps in new data only at frame boundaries, so no digit shows a torn value. Supports optional leading-zero blanking.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot; legal range >= 2.
- AN_ACTIVE_LOW, 1: when 1, anode outputs are inverted (active-low).
- SEG_ACTIVE_LOW, 1: when 1, segment outputs are inverted (active-low).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe; tied to the converter's done.
- bcd  in  20  packed BCD word: {d4,d3,d2,d1,d0}, 4 bits each, d0 = bits [3:0].
- blank_lz  in  1  leading-zero blanking enable; level input, sampled every cycle.
- an  out  5  digit enables, one-hot; an[0] = units.
- seg  out  7  {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async, rst=1):
  - Outputs: an = all inactive (5'b11111 when AN_ACTIVE_LOW=1); seg = all off (7'h7F when SEG_ACTIVE_LOW=1); frame_done = 0.
  - Internal state: divider = 0; digit index = 0; shadow = 0; frame register = 0; state = IDLE.
  - Reset asserted mid-scan blanks the display immediately (asynchronous).
- Divider: counts 0..CLK_DIV-1. tick = (divider == CLK_DIV-1); divider returns to 0 on tick.
- Digit index: 0..4; advances on tick; 4 -> 0 is the frame wrap.
- State machine:
  - IDLE: divider and index run; an and seg held inactive; no frame_done. load -> SCAN.
  - SCAN: normal scanning. Stays in SCAN until reset; no other exit.
- Shadow register:
  - On a load-cycle edge: shadow <= bcd.
  - Back-to-back loads: the last one wins.
- Frame register:
  - On tick with index == 4 (wrap): frame <= shadow.
  - If load coincides with the wrap tick, frame <= bcd directly (bypass; the new word is not lost or delayed).
  - In IDLE, the IDLE->SCAN load also writes frame <= bcd, so the first frame shows without waiting a full frame.
- Outputs (registered, updated on each tick in SCAN; 1-cycle latency from tick):
  - an: one-hot on the new index.
  - seg: decoded from frame digit[index].
  - A mid-frame load has no visible effect until the next wrap.
- frame_done: registered pulse, high for exactly the one cycle after each wrap tick in SCAN.
- Leading-zero blanking, for digit i = 1..4:
  - Blanked when blank_lz = 1 and d4..di are all zero.
  - A blanked digit has its anode deasserted and segments off.
  - Digit 0 is never blanked, so value 0 shows a single '0'.
- Decode (active-high, before polarity inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Invalid nibbles A-F show '-' = 40.
- Polarity: inversion is applied last, at the output register, per AN_ACTIVE_LOW and SEG_ACTIVE_LOW.
- Divider width: $clog2(CLK_DIV). The divider never exceeds CLK_DIV-1.

Decomposition:
- Shared package holds:
  - The seven-segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF).
  - The digit count constant N_DIGITS = 5.
  - The state encoding (IDLE, SCAN).
- One combinational sub-module, seg7_dec: 4-bit nibble in, 7-bit active-high pattern out.
- Divider, index, shadow, frame, blanking and output registers are all in the top module.

Test Plan (CLK_DIV=4, both polarity parameters = 1):
1. Reset with no load -> an=1F and seg=7F held for 40 cycles; frame_done never pulses.
2. load with bcd=20'h12345, blank_lz=0 -> anodes cycle 1E,1D,1B,17,0F, each held 4 cycles. seg (active-low) per slot: '5'=12, '4'=19, '3'=30, '2'=24, '1'=79. frame_done pulses every 20 cycles.
3. blank_lz=1, bcd=20'h00042 -> slots for digits 4,3,2 show an=1F and seg=7F; digit 1 shows '4'=19; digit 0 shows '2'=24.
4. blank_lz=1, bcd=0 -> only an[0] is ever active, with seg=40 ('0'); every other slot is blank.
5. While scanning 12345, load 20'h99999 at index 2 -> 12345 remains until the wrap; from the next frame every digit shows '9'=10. A load in the same cycle as the wrap tick shows the new value in that frame.
6. Nibble A in digit 0 -> seg=3F ('-'). Assert rst mid-slot -> an=1F and seg=7F in the same cycle. After release, the block is in IDLE and the display stays blank until the next load.
